// File: rtl/imem_boot_loader.sv
// Byte-serial boot loader: holds the CPU in reset, assembles big-endian
// instruction words from a byte stream and writes them into instruction memory.
module imem_boot_loader #(
  parameter int ADDR_W    = 6,
  parameter int MAX_WORDS = 64,
  parameter int TIMEOUT   = 1024
) (
  input  logic              sys_clk,
  input  logic              sys_reset,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // state | meaning
  // IDLE  | after reset, core held, waiting for load_start
  // LOAD  | accepting bytes, idle timeout running
  // WRITE | one-cycle instruction memory strobe
  // RUN   | program loaded, core released
  // ERR   | bad length or timeout, core held
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, RUN, ERR} state_t;

  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(MAX_WORDS);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);
  localparam logic [15:0]     TO_LAST = 16'(TIMEOUT - 1);

  state_t          state, state_n, start_state;
  logic [ADDR_W:0] len_q;
  logic [ADDR_W:0] word_cnt;
  logic [1:0]      byte_cnt;
  logic [23:0]     shift_q;
  logic [15:0]     idle_cnt;
  logic            xfer;

  assign xfer = (state == LOAD) && byte_valid && byte_ready;

  always_comb begin
    start_state = LOAD;
    if (load_len == '0)
      start_state = RUN;
    else if (load_len > MAX_LEN)
      start_state = ERR;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, RUN, ERR: begin
        if (load_start) state_n = start_state;
      end
      LOAD: begin
        if (load_start)
          state_n = start_state;
        else if (xfer && byte_cnt == 2'd3)
          state_n = WRITE;
        else if (!xfer && idle_cnt == TO_LAST)
          state_n = ERR;
      end
      WRITE: begin
        // the strobe is already on the outputs, so a restart only redirects
        if (load_start)
          state_n = start_state;
        else if (word_cnt == len_q - ONE)
          state_n = RUN;
        else
          state_n = LOAD;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      state      <= IDLE;
      len_q      <= '0;
      word_cnt   <= '0;
      byte_cnt   <= '0;
      shift_q    <= '0;
      idle_cnt   <= '0;
      byte_ready <= 1'b0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      byte_ready <= (state_n == LOAD);
      imem_we    <= (state_n == WRITE);
      busy       <= (state_n == LOAD) || (state_n == WRITE);
      done       <= (state_n == RUN);
      err        <= (state_n == ERR);
      cpu_reset  <= (state_n != RUN);

      if (load_start && (state == IDLE || state == LOAD || state == WRITE ||
                         state == RUN  || state == ERR)) begin
        len_q    <= load_len;
        word_cnt <= '0;
        byte_cnt <= '0;
        idle_cnt <= '0;
      end else begin
        case (state)
          LOAD: begin
            if (xfer) begin
              shift_q  <= {shift_q[15:0], byte_data};
              byte_cnt <= byte_cnt + 2'd1;
              idle_cnt <= '0;
              if (byte_cnt == 2'd3) begin
                imem_waddr <= word_cnt[ADDR_W-1:0];
                imem_wdata <= {shift_q, byte_data};
              end
            end else begin
              idle_cnt <= idle_cnt + 16'd1;
            end
          end
          WRITE: word_cnt <= word_cnt + ONE;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: single word, full program with gaps,
// timeout, length edges, restart and asynchronous reset.
module tb_imem_boot_loader;

  localparam int ADDR_W    = 6;
  localparam int MAX_WORDS = 64;
  localparam int TIMEOUT   = 1024;

  logic              sys_clk = 1'b0;
  logic              sys_reset;
  logic              load_start;
  logic [ADDR_W:0]   load_len;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset;
  logic              busy;
  logic              done;
  logic              err;

  int checks = 0;
  int errors = 0;
  int accepted = 0;
  logic [ADDR_W-1:0] wr_addr[$];
  logic [31:0]       wr_data[$];
  logic [7:0]        exp_b[256];

  imem_boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS), .TIMEOUT(TIMEOUT)) dut (
    .sys_clk(sys_clk), .sys_reset(sys_reset), .load_start(load_start),
    .load_len(load_len), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .busy(busy),
    .done(done), .err(err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge, so at the falling edge they are
  // exactly what the next rising edge will sample.
  always @(negedge sys_clk) begin
    if (!sys_reset) begin
      if (imem_we) begin
        wr_addr.push_back(imem_waddr);
        wr_data.push_back(imem_wdata);
        check("ready_low_in_write", {31'd0, byte_ready}, 32'd0);
      end
      if (byte_valid && byte_ready) accepted++;
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_start(input logic [ADDR_W:0] len);
    load_start = 1'b1;
    load_len   = len;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && n < 100) begin
      tick();
      n++;
    end
    if (!byte_ready) check("send_wait", 32'd0, 32'd1);
    tick();
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 50) begin
      tick();
      n++;
    end
    check("done_reached", {31'd0, done}, 32'd1);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  initial begin
    sys_reset  = 1'b1;
    load_start = 1'b0;
    load_len   = '0;
    byte_valid = 1'b0;
    byte_data  = '0;

    // reset values
    tick(); tick();
    check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("rst_imem_we", {31'd0, imem_we}, 32'd0);
    check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    sys_reset = 1'b0;
    tick();

    // single word, bytes back-to-back
    clear_log();
    do_start(7'd1);
    check("load_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h00);
    send_byte(8'h50);
    send_byte(8'h02);
    send_byte(8'h93);
    byte_valid = 1'b0;
    check("w1_we", {31'd0, imem_we}, 32'd1);
    check("w1_addr", {26'd0, imem_waddr}, 32'd0);
    check("w1_data", imem_wdata, 32'h00500293);
    check("w1_ready", {31'd0, byte_ready}, 32'd0);
    tick();
    check("w1_done", {31'd0, done}, 32'd1);
    check("w1_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    check("w1_we_off", {31'd0, imem_we}, 32'd0);
    check("w1_strobes", wr_addr.size(), 32'd1);

    // bytes in RUN are ignored
    byte_valid = 1'b1;
    byte_data  = 8'hff;
    tick(); tick();
    check("run_ignore_ready", {31'd0, byte_ready}, 32'd0);
    check("run_ignore_we", wr_addr.size(), 32'd1);
    byte_valid = 1'b0;

    // leaving RUN with a bad length: core held in the same cycle
    do_start(7'd65);
    check("len65_err", {31'd0, err}, 32'd1);
    check("len65_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("len65_done", {31'd0, done}, 32'd0);

    // zero length from ERR
    clear_log();
    do_start(7'd0);
    check("len0_done", {31'd0, done}, 32'd1);
    check("len0_err", {31'd0, err}, 32'd0);
    check("len0_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    tick();
    check("len0_no_we", wr_addr.size(), 32'd0);

    // restart from RUN, then restart mid-word
    do_start(7'd2);
    check("run_exit_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("run_exit_done", {31'd0, done}, 32'd0);
    send_byte(8'haa);
    send_byte(8'hbb);
    byte_valid = 1'b0;
    do_start(7'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    byte_valid = 1'b0;
    check("rs_we", {31'd0, imem_we}, 32'd1);
    check("rs_addr", {26'd0, imem_waddr}, 32'd0);
    check("rs_data", imem_wdata, 32'h11223344);
    wait_done();
    check("rs_strobes", wr_addr.size(), 32'd1);

    // full program with random gaps
    clear_log();
    accepted = 0;
    for (int i = 0; i < 256; i++) exp_b[i] = 8'(i * 37 + 5);
    do_start(7'd64);
    for (int i = 0; i < 256; i++) begin
      byte_valid = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
      send_byte(exp_b[i]);
    end
    byte_valid = 1'b0;
    wait_done();
    check("full_strobes", wr_addr.size(), 32'd64);
    check("full_bytes", accepted, 32'd256);
    for (int w = 0; w < 64 && w < wr_addr.size(); w++) begin
      check($sformatf("full_addr_%0d", w), {26'd0, wr_addr[w]}, w);
      check($sformatf("full_data_%0d", w), wr_data[w],
            {exp_b[4*w], exp_b[4*w+1], exp_b[4*w+2], exp_b[4*w+3]});
    end

    // timeout after a partial word
    clear_log();
    do_start(7'd2);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    byte_valid = 1'b0;
    repeat (TIMEOUT - 5) tick();
    check("to_not_yet", {31'd0, err}, 32'd0);
    check("to_still_busy", {31'd0, busy}, 32'd1);
    for (int n = 0; n < 20 && !err; n++) tick();
    check("to_err", {31'd0, err}, 32'd1);
    check("to_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("to_no_we", wr_addr.size(), 32'd0);
    do_start(7'd1);
    send_byte(8'hde);
    send_byte(8'had);
    send_byte(8'hbe);
    send_byte(8'hef);
    byte_valid = 1'b0;
    wait_done();
    check("to_recover_err", {31'd0, err}, 32'd0);
    check("to_recover_data", (wr_data.size() == 1) ? wr_data[0] : 32'hx, 32'hdeadbeef);

    // asynchronous reset in the middle of a word
    clear_log();
    do_start(7'd1);
    send_byte(8'h12);
    send_byte(8'h34);
    #2;
    sys_reset = 1'b1;
    #1;
    check("mid_rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("mid_rst_ready", {31'd0, byte_ready}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_wdata", imem_wdata, 32'd0);
    byte_valid = 1'b0;
    tick(); tick();
    check("mid_rst_we", {31'd0, imem_we}, 32'd0);
    sys_reset = 1'b0;
    tick(); tick();
    check("mid_rst_no_strobe", wr_addr.size(), 32'd0);
    check("mid_rst_idle_cpu", {31'd0, cpu_reset}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
